cpu6_excpctrl: RTL and testbench

- Trap/return sequencer for the cpu6 core.
- Detects timer interrupt, ECALL and MRET in EX, and drives the pipeline-drain handshake (empty_pipeline_reqE / empty_pipeline_ackW).
- After the drain, writes mepc/mcause into the CSR block and redirects fetch to mtvec (trap) or mepc (return).
- Sits beside cpu6_datapath in the cpu6 top and owns fetch stall/flush during trap entry and exit.

---
 rtl/cpu6_excpctrl_pkg.sv | 23 ++
 rtl/cpu6_excpctrl.sv | 135 +++++++++++++
 tb/tb_cpu6_excpctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/cpu6_excpctrl_pkg.sv
// Shared encodings for the cpu6 trap/return sequencer: FSM states,
// captured event kinds and the mcause values it writes.
package cpu6_excpctrl_pkg;

    localparam int CPU6_EXCPCTRL_STATE_SIZE = 2;

    typedef enum logic [CPU6_EXCPCTRL_STATE_SIZE-1:0] {
        CPU6_EXCP_IDLE     = 2'd0,
        CPU6_EXCP_DRAIN    = 2'd1,
        CPU6_EXCP_SAVE     = 2'd2,
        CPU6_EXCP_REDIRECT = 2'd3
    } excp_state_e;

    typedef enum logic [1:0] {
        CPU6_EXCP_KIND_TRAP_ECALL = 2'd0,
        CPU6_EXCP_KIND_TRAP_IRQ   = 2'd1,
        CPU6_EXCP_KIND_RET        = 2'd2
    } excp_kind_e;

    localparam logic [31:0] CPU6_MCAUSE_ECALL_M = 32'h0000_000B;
    localparam logic [31:0] CPU6_MCAUSE_MTIMER  = 32'h8000_0007;

endpackage

// File: rtl/cpu6_excpctrl.sv
// Trap/return sequencer: accepts ECALL/MRET/timer irq in EX, drains the
// pipeline, writes mepc/mcause and redirects fetch to mtvec or mepc.
module cpu6_excpctrl
    import cpu6_excpctrl_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int DRAIN_TIMEOUT = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            validE,
    input  logic            ecallE,
    input  logic            mretE,
    input  logic [XLEN-1:0] pcE,
    input  logic [XLEN-1:0] pcnextE,
    input  logic            tmr_irq_r,
    input  logic [XLEN-1:0] csr_mtvec,
    input  logic [XLEN-1:0] csr_mepc,
    output logic            empty_pipeline_reqE,
    input  logic            empty_pipeline_ackW,
    output logic [XLEN-1:0] excp_mepc,
    output logic            excp_mepc_ena,
    output logic [XLEN-1:0] excp_mcause,
    output logic            stallF,
    output logic            flushD,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            in_trap,
    output logic            timeout_err
);

    localparam int CNT_W = $clog2(DRAIN_TIMEOUT + 1);

    excp_state_e     state_q, state_d;
    excp_kind_e      kind_q, kind_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic [XLEN-1:0] cause_q, cause_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            in_trap_q, in_trap_d;
    logic            timeout_q, timeout_d;

    logic ecall_ev, mret_ev, irq_ev, accept, drain_limit;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d     = state_q;
        kind_d      = kind_q;
        epc_d       = epc_q;
        cause_d     = cause_q;
        cnt_d       = cnt_q;
        in_trap_d   = in_trap_q;
        timeout_d   = timeout_q;

        ecall_ev    = validE & ecallE;
        mret_ev     = validE & mretE;
        irq_ev      = tmr_irq_r & ~in_trap_q;
        // Gated by reset so the accept-cycle outputs also read 0 while reset is held.
        accept      = ~reset & (state_q == CPU6_EXCP_IDLE) & (ecall_ev | mret_ev | irq_ev);
        drain_limit = (cnt_q == CNT_W'(DRAIN_TIMEOUT - 1));

        case (state_q)
            CPU6_EXCP_IDLE: begin
                if (accept) begin
                    state_d = CPU6_EXCP_DRAIN;
                    cnt_d   = '0;
                    if (ecall_ev) begin
                        kind_d  = CPU6_EXCP_KIND_TRAP_ECALL;
                        epc_d   = pcE;
                        cause_d = XLEN'(CPU6_MCAUSE_ECALL_M);
                    end else if (mret_ev) begin
                        kind_d  = CPU6_EXCP_KIND_RET;
                    end else begin
                        kind_d  = CPU6_EXCP_KIND_TRAP_IRQ;
                        epc_d   = pcnextE;
                        cause_d = XLEN'(CPU6_MCAUSE_MTIMER);
                    end
                end
            end
            CPU6_EXCP_DRAIN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (empty_pipeline_ackW || drain_limit) begin
                    if (!empty_pipeline_ackW) begin
                        timeout_d = 1'b1;
                    end
                    state_d = (kind_q == CPU6_EXCP_KIND_RET) ? CPU6_EXCP_REDIRECT
                                                             : CPU6_EXCP_SAVE;
                end
            end
            CPU6_EXCP_SAVE: begin
                state_d = CPU6_EXCP_REDIRECT;
            end
            CPU6_EXCP_REDIRECT: begin
                state_d   = CPU6_EXCP_IDLE;
                in_trap_d = (kind_q != CPU6_EXCP_KIND_RET);
            end
            default: state_d = CPU6_EXCP_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= CPU6_EXCP_IDLE;
            kind_q    <= CPU6_EXCP_KIND_TRAP_ECALL;
            epc_q     <= '0;
            cause_q   <= '0;
            cnt_q     <= '0;
            in_trap_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            epc_q     <= epc_d;
            cause_q   <= cause_d;
            cnt_q     <= cnt_d;
            in_trap_q <= in_trap_d;
            timeout_q <= timeout_d;
        end
    end

    assign empty_pipeline_reqE = accept;
    assign flushD              = accept;
    assign stallF              = accept | (state_q != CPU6_EXCP_IDLE);
    assign excp_mepc_ena       = (state_q == CPU6_EXCP_SAVE);
    assign excp_mepc           = epc_q;
    assign excp_mcause         = cause_q;
    assign redirect_valid      = (state_q == CPU6_EXCP_REDIRECT);
    // Trap vectors are word aligned; the mode bits of mtvec are dropped.
    assign redirect_pc         = !redirect_valid ? '0 :
                                 (kind_q == CPU6_EXCP_KIND_RET) ? csr_mepc
                                                                : (csr_mtvec & ~XLEN'(3));
    assign in_trap             = in_trap_q;
    assign timeout_err         = timeout_q;

endmodule

// File: tb/tb_cpu6_excpctrl.sv
// Directed bench for cpu6_excpctrl: inputs are driven on the falling edge and
// outputs are checked 1ns later, well away from the rising edge.
module tb_cpu6_excpctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        validE, ecallE, mretE;
    logic [31:0] pcE, pcnextE;
    logic        tmr_irq_r;
    logic [31:0] csr_mtvec, csr_mepc;
    logic        empty_pipeline_reqE, empty_pipeline_ackW;
    logic [31:0] excp_mepc, excp_mcause, redirect_pc;
    logic        excp_mepc_ena, stallF, flushD, redirect_valid, in_trap, timeout_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cpu6_excpctrl #(.XLEN(32), .DRAIN_TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .validE(validE), .ecallE(ecallE), .mretE(mretE),
        .pcE(pcE), .pcnextE(pcnextE), .tmr_irq_r(tmr_irq_r),
        .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
        .empty_pipeline_reqE(empty_pipeline_reqE), .empty_pipeline_ackW(empty_pipeline_ackW),
        .excp_mepc(excp_mepc), .excp_mepc_ena(excp_mepc_ena), .excp_mcause(excp_mcause),
        .stallF(stallF), .flushD(flushD),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .in_trap(in_trap), .timeout_err(timeout_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_instr();
        validE = 1'b0; ecallE = 1'b0; mretE = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_req"},   {31'd0, empty_pipeline_reqE}, 32'd0);
        check({tag, "_ena"},   {31'd0, excp_mepc_ena},       32'd0);
        check({tag, "_redir"}, {31'd0, redirect_valid},      32'd0);
    endtask

    initial begin
        reset = 1'b1; clear_instr();
        pcE = 32'h0; pcnextE = 32'h0; tmr_irq_r = 1'b0;
        csr_mtvec = 32'h201; csr_mepc = 32'h0; empty_pipeline_ackW = 1'b0;

        // Reset state
        tick(); settle();
        check("rst_stall",   {31'd0, stallF}, 32'd0);
        check("rst_flush",   {31'd0, flushD}, 32'd0);
        check("rst_intrap",  {31'd0, in_trap}, 32'd0);
        check("rst_tmo",     {31'd0, timeout_err}, 32'd0);
        check("rst_mepc",    excp_mepc, 32'd0);
        check("rst_rpc",     redirect_pc, 32'd0);
        check_quiet("rst");
        tick(); reset = 1'b0;

        // ECALL at 0x100, ack at T+1
        tick(); validE = 1'b1; ecallE = 1'b1; pcE = 32'h100; pcnextE = 32'h104; settle();
        check("ec_T_req",   {31'd0, empty_pipeline_reqE}, 32'd1);
        check("ec_T_flush", {31'd0, flushD}, 32'd1);
        check("ec_T_stall", {31'd0, stallF}, 32'd1);
        tick(); clear_instr(); empty_pipeline_ackW = 1'b1; settle();
        check("ec_T1_req",   {31'd0, empty_pipeline_reqE}, 32'd0);
        check("ec_T1_flush", {31'd0, flushD}, 32'd0);
        check("ec_T1_stall", {31'd0, stallF}, 32'd1);
        check("ec_T1_ena",   {31'd0, excp_mepc_ena}, 32'd0);
        tick(); empty_pipeline_ackW = 1'b0; settle();
        check("ec_T2_ena",   {31'd0, excp_mepc_ena}, 32'd1);
        check("ec_T2_mepc",  excp_mepc, 32'h100);
        check("ec_T2_cause", excp_mcause, 32'h0000000B);
        check("ec_T2_redir", {31'd0, redirect_valid}, 32'd0);
        tick(); settle();
        check("ec_T3_redir",  {31'd0, redirect_valid}, 32'd1);
        check("ec_T3_pc",     redirect_pc, 32'h200);
        check("ec_T3_intrap", {31'd0, in_trap}, 32'd0);
        check("ec_T3_ena",    {31'd0, excp_mepc_ena}, 32'd0);
        tick(); settle();
        check("ec_T4_intrap", {31'd0, in_trap}, 32'd1);
        check("ec_T4_stall",  {31'd0, stallF}, 32'd0);
        check("ec_T4_hold",   excp_mepc, 32'h100);
        check_quiet("ec_T4");

        // MRET to 0x104 with irq raised during the return
        tick(); validE = 1'b1; mretE = 1'b1; csr_mepc = 32'h104; settle();
        check("mr_T_req", {31'd0, empty_pipeline_reqE}, 32'd1);
        tick(); clear_instr(); empty_pipeline_ackW = 1'b1; tmr_irq_r = 1'b1; settle();
        check("mr_T1_req", {31'd0, empty_pipeline_reqE}, 32'd0);
        check("mr_T1_ena", {31'd0, excp_mepc_ena}, 32'd0);
        tick(); empty_pipeline_ackW = 1'b0; settle();
        check("mr_T2_redir",  {31'd0, redirect_valid}, 32'd1);
        check("mr_T2_pc",     redirect_pc, 32'h104);
        check("mr_T2_ena",    {31'd0, excp_mepc_ena}, 32'd0);
        check("mr_T2_intrap", {31'd0, in_trap}, 32'd1);

        // Pending irq taken on the first IDLE cycle after MRET
        tick(); validE = 1'b1; pcE = 32'h44; pcnextE = 32'h48; settle();
        check("irq_T_intrap", {31'd0, in_trap}, 32'd0);
        check("irq_T_req",    {31'd0, empty_pipeline_reqE}, 32'd1);
        tick(); clear_instr(); empty_pipeline_ackW = 1'b1; settle();
        check("irq_T1_req", {31'd0, empty_pipeline_reqE}, 32'd0);
        tick(); empty_pipeline_ackW = 1'b0; settle();
        check("irq_T2_ena",   {31'd0, excp_mepc_ena}, 32'd1);
        check("irq_T2_mepc",  excp_mepc, 32'h48);
        check("irq_T2_cause", excp_mcause, 32'h80000007);
        tick(); settle();
        check("irq_T3_pc", redirect_pc, 32'h200);
        tick(); validE = 1'b1; pcE = 32'h200; pcnextE = 32'h204; settle();
        check("irq_T4_intrap", {31'd0, in_trap}, 32'd1);
        check("irq_T4_noretake", {31'd0, empty_pipeline_reqE}, 32'd0);
        tick(); settle();
        check("irq_T5_noretake", {31'd0, empty_pipeline_reqE}, 32'd0);
        check("irq_T5_stall", {31'd0, stallF}, 32'd0);

        // MRET with irq dropped, then ECALL and irq together
        tick(); tmr_irq_r = 1'b0; mretE = 1'b1; csr_mepc = 32'h2F0; settle();
        check("mr2_T_req", {31'd0, empty_pipeline_reqE}, 32'd1);
        tick(); clear_instr(); empty_pipeline_ackW = 1'b1; settle();
        tick(); empty_pipeline_ackW = 1'b0; settle();
        check("mr2_T2_pc", redirect_pc, 32'h2F0);
        tick(); validE = 1'b1; ecallE = 1'b1; tmr_irq_r = 1'b1; pcE = 32'h300; pcnextE = 32'h304; settle();
        check("both_T_intrap", {31'd0, in_trap}, 32'd0);
        check("both_T_req",    {31'd0, empty_pipeline_reqE}, 32'd1);
        tick(); clear_instr(); empty_pipeline_ackW = 1'b1; settle();
        tick(); empty_pipeline_ackW = 1'b0; settle();
        check("both_T2_ena",   {31'd0, excp_mepc_ena}, 32'd1);
        check("both_T2_mepc",  excp_mepc, 32'h300);
        check("both_T2_cause", excp_mcause, 32'h0000000B);
        tick(); settle();
        check("both_T3_redir", {31'd0, redirect_valid}, 32'd1);
        tick(); validE = 1'b1; mretE = 1'b1; csr_mepc = 32'h304; settle();
        check("both_mret_req", {31'd0, empty_pipeline_reqE}, 32'd1);
        tick(); clear_instr(); empty_pipeline_ackW = 1'b1; settle();
        tick(); empty_pipeline_ackW = 1'b0; settle();
        check("both_mret_pc", redirect_pc, 32'h304);
        tick(); pcE = 32'h304; pcnextE = 32'h304; settle();
        check("both_irq_req", {31'd0, empty_pipeline_reqE}, 32'd1);
        tick(); tmr_irq_r = 1'b0; empty_pipeline_ackW = 1'b1; settle();
        tick(); empty_pipeline_ackW = 1'b0; settle();
        check("both_irq_mepc",  excp_mepc, 32'h304);
        check("both_irq_cause", excp_mcause, 32'h80000007);
        tick(); settle();
        check("both_irq_redir", {31'd0, redirect_valid}, 32'd1);

        // Nested ECALL with ack withheld: drain times out after 8 cycles
        tick(); validE = 1'b1; ecallE = 1'b1; pcE = 32'h500; pcnextE = 32'h504; settle();
        check("to_T_intrap", {31'd0, in_trap}, 32'd1);
        check("to_T_req",    {31'd0, empty_pipeline_reqE}, 32'd1);
        tick(); clear_instr(); settle();
        for (int i = 2; i <= 8; i++) begin
            tick(); settle();
        end
        check("to_T8_stall", {31'd0, stallF}, 32'd1);
        check("to_T8_ena",   {31'd0, excp_mepc_ena}, 32'd0);
        check("to_T8_tmo",   {31'd0, timeout_err}, 32'd0);
        tick(); settle();
        check("to_T9_tmo",  {31'd0, timeout_err}, 32'd1);
        check("to_T9_ena",  {31'd0, excp_mepc_ena}, 32'd1);
        check("to_T9_mepc", excp_mepc, 32'h500);
        tick(); settle();
        check("to_T10_redir", {31'd0, redirect_valid}, 32'd1);
        check("to_T10_pc",    redirect_pc, 32'h200);
        tick(); empty_pipeline_ackW = 1'b1; settle();
        check("to_T11_tmo",   {31'd0, timeout_err}, 32'd1);
        check("to_T11_stall", {31'd0, stallF}, 32'd0);
        tick(); empty_pipeline_ackW = 1'b0; settle();
        check("to_T12_stall", {31'd0, stallF}, 32'd0);
        check("to_T12_tmo",   {31'd0, timeout_err}, 32'd1);

        // Reset in the middle of a drain
        tick(); validE = 1'b1; ecallE = 1'b1; pcE = 32'h600; settle();
        check("rs_T_req", {31'd0, empty_pipeline_reqE}, 32'd1);
        tick(); clear_instr(); settle();
        check("rs_T1_stall", {31'd0, stallF}, 32'd1);
        reset = 1'b1; settle();
        check("rs_stall",  {31'd0, stallF}, 32'd0);
        check("rs_intrap", {31'd0, in_trap}, 32'd0);
        check("rs_tmo",    {31'd0, timeout_err}, 32'd0);
        check("rs_mepc",   excp_mepc, 32'd0);
        check("rs_cause",  excp_mcause, 32'd0);
        tick(); empty_pipeline_ackW = 1'b1; settle();
        check_quiet("rs_hold");
        tick(); reset = 1'b0; settle();
        check_quiet("rs_rel");
        tick(); empty_pipeline_ackW = 1'b0; settle();
        check_quiet("rs_after1");
        check("rs_after1_stall", {31'd0, stallF}, 32'd0);
        tick(); settle();
        check_quiet("rs_after2");

        // Fresh ECALL after reset completes normally
        tick(); csr_mtvec = 32'h403; validE = 1'b1; ecallE = 1'b1; pcE = 32'h700; settle();
        check("re_T_req", {31'd0, empty_pipeline_reqE}, 32'd1);
        tick(); clear_instr(); empty_pipeline_ackW = 1'b1; settle();
        tick(); empty_pipeline_ackW = 1'b0; settle();
        check("re_T2_ena",  {31'd0, excp_mepc_ena}, 32'd1);
        check("re_T2_mepc", excp_mepc, 32'h700);
        tick(); settle();
        check("re_T3_redir", {31'd0, redirect_valid}, 32'd1);
        check("re_T3_pc",    redirect_pc, 32'h400);
        tick(); settle();
        check("re_T4_intrap", {31'd0, in_trap}, 32'd1);
        check("re_T4_tmo",    {31'd0, timeout_err}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
